uart_rx_axis_param: RTL and testbench
=====================================

# uart_rx_axis_param

Parametrised UART receiver with an AXI4-Stream master output, an internal elastic FIFO and per-character error flags. It converts the asynchronous UART_RX line into one stream beat per received character. It is configurable in character width, parity mode and stop-bit count, and sits between the board RX pin and any AXIS consumer (command parser, DMA, loopback). It replaces the fixed 8N1 receiver-plus-handshake pairing, which held a single byte and stalled while the downstream FIFO was almost full.

## Interface
- DATA_BITS, 8: character width, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: number of entries, power of two, at least 2.
- aclk  in  1  single clock for all logic.
- aresetn  in  1  synchronous, active-low reset.
- UART_RX  in  1  asynchronous serial line, idle high.
- clk_en_16_x_baud  in  1  one-cycle tick at 16x the baud rate.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  a FIFO entry is available.
- m_axis_tdata  out  DATA_BITS  received character, LSB first on the line.
- m_axis_tuser  out  2  bit 1 = parity error, bit 0 = framing error.
- overrun  out  1  one-cycle pulse when a completed character is dropped because the FIFO is full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
**Input sampling**
- UART_RX passes through a 2-flop synchroniser (rx_s) before any use.
- A bit counter runs 0..15 and advances only on clk_en_16_x_baud.
- Each bit value is the majority of rx_s sampled at ticks 6, 7 and 8. The bit is resolved at tick 8.

**Receiver FSM**
- IDLE: stays here until rx_s == 0 on a tick, then clears the counter and goes to START.
- START: if the majority result is 1, it was a false start; return to IDLE. Otherwise go to DATA at tick 15.
- DATA: shift DATA_BITS bits in, LSB first.
  - After the last bit, go to PARITY if PARITY != 0, else go to STOP.
- PARITY: compute the error by XOR of the data bits and the received parity bit against the selected mode.
- STOP: sample STOP_BITS stop bits. Any stop sample of 0 sets the framing error.
  - The character is complete at tick 8 of the final stop bit.
- Completion with no framing error: return to IDLE immediately at that tick, so back-to-back characters with no gap are accepted.
- Completion with a framing error: go to WAIT_IDLE. The FSM stays there until rx_s == 1 on a tick, then goes to IDLE.
  - A line break therefore produces exactly one entry: all-zero data with tuser[0] set.

**FIFO**
- On completion, push {tuser, data} into the FIFO.
- If the FIFO is full and no pop happens in the same cycle, drop the character and pulse overrun.
- A push and a pop in the same cycle while full are both accepted. fifo_level does not change.
- A push and a pop in the same cycle while empty: the pop is not possible, so the push lands and level becomes 1.
- Read pointer, write pointer and level are $clog2(FIFO_DEPTH)+1 bits. Full when level == FIFO_DEPTH.

**AXIS output**
- The output is first-word-fall-through: m_axis_tvalid = (level != 0).
- tdata/tuser show the head entry. They are driven to 0 while tvalid is 0.
- A pop happens on tvalid && tready.
- tdata and tuser are stable while tvalid && !tready.
- tvalid never deasserts without a handshake.

## Timing
**Reset values**
- m_axis_tvalid 0, m_axis_tdata 0, m_axis_tuser 0, overrun 0, fifo_level 0.
- FSM in IDLE, synchroniser flops set to 1.
- FIFO storage is not reset.

**Reset mid-frame**
- A partial character is discarded.
- After reset, the FSM waits in IDLE for a falling edge. A low line during reset release is treated as a start on the first tick.

**Latencies**
- Pin to rx_s: 2 aclk.
- Completion tick to m_axis_tvalid high (FIFO was empty): 1 aclk. The push registers on the completion edge.
- Pop to next head visible: same cycle as the level update, i.e. 1 aclk after the handshake edge.
- overrun asserts in the cycle after the dropped completion, for exactly 1 aclk.

**Continuous throughput**
- The FIFO never overruns when tready is held high, regardless of FIFO_DEPTH.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the rx state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - OVS = 16 and the sample tick constants 6, 7, 8;
  - tuser bit indices.
- Sub-module uart_axis_fifo, parametrised by WIDTH and DEPTH:
  - synchronous FWFT FIFO with level output;
  - reusable by the TX side.
- Top level contains the synchroniser, the FSM, the shifter and the parity/frame checks.
- Parameter legality is checked with elaboration-time errors.

## Test plan
- **8N1, char 0xA5, tready = 1:** one beat with tdata = 0xA5, tuser = 0, tvalid high 1 aclk after the stop-bit tick 8.
- **PARITY = 2 (even), DATA_BITS = 7, char 0x41 sent with a wrong parity bit:** tdata = 0x41, tuser = 2'b10.
- **Line held low for 2 character times (break), 8N1:**
  - exactly one beat with tdata = 0x00, tuser = 2'b01;
  - no further beats until the line goes high and a new start arrives.
- **FIFO_DEPTH = 4, tready = 0, send 0x01..0x05 back to back:**
  - fifo_level reaches 4 and overrun pulses once, on 0x05;
  - raising tready then drains 0x01, 0x02, 0x03, 0x04 in order.
- **Glitch low of 4 ticks on an idle line:** FSM returns to IDLE with no beat. A following valid 0x3C is received correctly.
- **Reset mid-character, then a clean 0x5A:**
  - all outputs are 0 during reset;
  - only 0x5A is emitted afterwards;
  - tdata is held stable across 3 cycles of tready = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, receiver state encoding, oversampling
// ticks and stream sideband bit positions.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   localparam int unsigned OVS   = 16;
   localparam int unsigned CNT_W = $clog2(OVS);

   localparam logic [CNT_W-1:0] TICK_S0   = CNT_W'(6);
   localparam logic [CNT_W-1:0] TICK_S1   = CNT_W'(7);
   localparam logic [CNT_W-1:0] TICK_S2   = CNT_W'(8);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVS - 1);

   localparam int unsigned TUSER_W  = 2;
   localparam int unsigned TUSER_FE = 0;
   localparam int unsigned TUSER_PE = 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

endpackage

// File: rtl/uart_rx_axis_param_if.sv
// AXI4-Stream beat carrying one received character plus its error flags.
interface uart_rx_axis_param_if #(
   parameter int unsigned DATA_BITS = 8
) ();
   import uart_pkg::*;

   logic                 tvalid;
   logic                 tready;
   logic [DATA_BITS-1:0] tdata;
   logic [TUSER_W-1:0]   tuser;

   modport master (output tvalid, output tdata, output tuser, input tready);
   modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/uart_axis_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, level and
// drop pulse; the head register is zero whenever the FIFO is empty.
module uart_axis_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic                   o_valid,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_overrun
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_axis_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd, r_wr, r_level;
   logic             r_valid, r_overrun;
   logic [WIDTH-1:0] r_head;

   logic             w_full, w_pop_ok, w_push_ok;
   logic [PTR_W-1:0] w_rd_n, w_wr_n, w_level_n;
   logic [WIDTH-1:0] w_head_n;

   // A push while full survives only if the head leaves in the same cycle.
   always_comb begin
      w_full    = (r_level == PTR_W'(DEPTH));
      w_pop_ok  = i_pop && (r_level != '0);
      w_push_ok = i_push && (!w_full || w_pop_ok);
      w_rd_n    = r_rd + PTR_W'(w_pop_ok);
      w_wr_n    = r_wr + PTR_W'(w_push_ok);
      w_level_n = r_level + PTR_W'(w_push_ok) - PTR_W'(w_pop_ok);
      w_head_n  = '0;
      if (w_level_n == '0) begin
         w_head_n = '0;
      end else if (w_push_ok && (r_level == PTR_W'(w_pop_ok))) begin
         w_head_n = i_wdata;
      end else begin
         w_head_n = r_mem[w_rd_n[IDX_W-1:0]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd      <= '0;
         r_wr      <= '0;
         r_level   <= '0;
         r_valid   <= 1'b0;
         r_head    <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_rd      <= w_rd_n;
         r_wr      <= w_wr_n;
         r_level   <= w_level_n;
         r_valid   <= (w_level_n != '0);
         r_head    <= w_head_n;
         r_overrun <= i_push && !w_push_ok;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr[IDX_W-1:0]] <= i_wdata;
      end
   end

   assign o_valid   = r_valid;
   assign o_rdata   = r_head;
   assign o_level   = r_level;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_axis_param.sv
// Parametrised UART receiver: synchroniser, 16x oversampling FSM with
// majority voting, parity/framing checks and an elastic FWFT stream FIFO.
module uart_rx_axis_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        UART_RX,
   input  logic                        clk_en_16_x_baud,
   uart_rx_axis_param_if.master        m_axis,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned BIT_W = 4;
   localparam int unsigned TW    = DATA_BITS + TUSER_W;

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_rx_axis_param: DATA_BITS must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
      $error("uart_rx_axis_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_axis_param: STOP_BITS must be 1 or 2");
   end

   logic                 r_rx_meta, r_rx_s;
   rx_state_e            r_state, w_state_n;
   logic [CNT_W-1:0]     r_cnt, w_cnt_n;
   logic                 r_s0, r_s1, w_s0_n, w_s1_n;
   logic [DATA_BITS-1:0] r_shift, w_shift_n;
   logic [BIT_W-1:0]     r_bit_idx, w_bit_idx_n;
   logic                 r_stop_idx, w_stop_idx_n;
   logic                 r_pe, w_pe_n, r_fe, w_fe_n;

   logic                 w_maj, w_fe_now, w_push;
   logic [TUSER_W-1:0]   w_push_user;
   logic                 w_fifo_valid;
   logic [TW-1:0]        w_fifo_rdata;

   assign w_maj = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);

   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_s0_n       = r_s0;
      w_s1_n       = r_s1;
      w_shift_n    = r_shift;
      w_bit_idx_n  = r_bit_idx;
      w_stop_idx_n = r_stop_idx;
      w_pe_n       = r_pe;
      w_fe_n       = r_fe;
      w_fe_now     = r_fe | ~w_maj;
      w_push       = 1'b0;
      w_push_user  = '0;
      if (clk_en_16_x_baud) begin
         w_cnt_n = r_cnt + CNT_W'(1);
         if (r_cnt == TICK_S0) w_s0_n = r_rx_s;
         if (r_cnt == TICK_S1) w_s1_n = r_rx_s;
         case (r_state)
            RX_IDLE: begin
               w_cnt_n = '0;
               if (!r_rx_s) w_state_n = RX_START;
            end
            RX_START: begin
               if (r_cnt == TICK_S2 && w_maj) begin
                  w_state_n = RX_IDLE;
               end else if (r_cnt == TICK_LAST) begin
                  w_state_n   = RX_DATA;
                  w_bit_idx_n = '0;
                  w_pe_n      = 1'b0;
                  w_fe_n      = 1'b0;
               end
            end
            RX_DATA: begin
               // LSB arrives first, so shift in from the top.
               if (r_cnt == TICK_S2) w_shift_n = {w_maj, r_shift[DATA_BITS-1:1]};
               if (r_cnt == TICK_LAST) begin
                  w_bit_idx_n  = r_bit_idx + BIT_W'(1);
                  w_stop_idx_n = 1'b0;
                  if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                     w_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                  end
               end
            end
            RX_PARITY: begin
               if (r_cnt == TICK_S2) begin
                  w_pe_n = (PARITY == PAR_EVEN) ? (^r_shift ^ w_maj) : ~(^r_shift ^ w_maj);
               end
               if (r_cnt == TICK_LAST) w_state_n = RX_STOP;
            end
            RX_STOP: begin
               if (r_cnt == TICK_S2) begin
                  w_fe_n = w_fe_now;
                  if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                     w_push                = 1'b1;
                     w_push_user[TUSER_PE] = r_pe;
                     w_push_user[TUSER_FE] = w_fe_now;
                     w_state_n             = w_fe_now ? RX_WAIT_IDLE : RX_IDLE;
                  end
               end
               if (r_cnt == TICK_LAST) w_stop_idx_n = 1'b1;
            end
            RX_WAIT_IDLE: begin
               if (r_rx_s) w_state_n = RX_IDLE;
            end
            default: w_state_n = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_state    <= RX_IDLE;
         r_cnt      <= '0;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_pe       <= 1'b0;
         r_fe       <= 1'b0;
      end else begin
         r_rx_meta  <= UART_RX;
         r_rx_s     <= r_rx_meta;
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_s0       <= w_s0_n;
         r_s1       <= w_s1_n;
         r_shift    <= w_shift_n;
         r_bit_idx  <= w_bit_idx_n;
         r_stop_idx <= w_stop_idx_n;
         r_pe       <= w_pe_n;
         r_fe       <= w_fe_n;
      end
   end

   uart_axis_fifo #(
      .WIDTH (TW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (aclk),
      .i_rst_n   (aresetn),
      .i_push    (w_push),
      .i_wdata   ({w_push_user, r_shift}),
      .i_pop     (w_fifo_valid & m_axis.tready),
      .o_valid   (w_fifo_valid),
      .o_rdata   (w_fifo_rdata),
      .o_level   (fifo_level),
      .o_overrun (overrun)
   );

   assign m_axis.tvalid = w_fifo_valid;
   assign m_axis.tdata  = w_fifo_rdata[DATA_BITS-1:0];
   assign m_axis.tuser  = w_fifo_rdata[TW-1 -: TUSER_W];

endmodule

// File: tb/tb_uart_rx_axis_param.sv
// Bench for uart_rx_axis_param: an 8N1 instance and a 7E2 instance driven by
// a bit-level line model and checked against expected character queues.
module tb_uart_rx_axis_param;

   localparam int unsigned BIT_CLKS = 64;  // 16 ticks x 4 clocks per tick

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic       tick = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       ovr_a, ovr_b;
   logic [2:0] lvl_a, lvl_b;
   int         tick_div = 0;
   int         mode_a = 1;
   int         mode_b = 1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_stop_cyc = 0;
   int stab_viol = 0;
   int zero_viol = 0;
   int ovr_cnt_a = 0;
   logic        hold_a = 1'b0, hold_b = 1'b0;
   logic [9:0]  hold_val_a = '0;
   logic [8:0]  hold_val_b = '0;

   logic [10:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   int          got_a_cyc[$];

   uart_rx_axis_param_if #(.DATA_BITS(8)) ax_a ();
   uart_rx_axis_param_if #(.DATA_BITS(7)) ax_b ();

   uart_rx_axis_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .aclk(clk), .aresetn(aresetn), .UART_RX(rx_a), .clk_en_16_x_baud(tick),
      .m_axis(ax_a), .overrun(ovr_a), .fifo_level(lvl_a));

   uart_rx_axis_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .aclk(clk), .aresetn(aresetn), .UART_RX(rx_b), .clk_en_16_x_baud(tick),
      .m_axis(ax_b), .overrun(ovr_b), .fifo_level(lvl_b));

   initial forever #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk); #1;
         tick = (tick_div == 3);
         tick_div = (tick_div + 1) % 4;
      end
   end

   // tready policy per instance: 0 = low, 1 = high, 2 = random
   initial begin
      ax_a.tready = 1'b0;
      ax_b.tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         ax_a.tready = (mode_a == 2) ? 1'($urandom_range(0, 1)) : (mode_a == 1);
         ax_b.tready = (mode_b == 2) ? 1'($urandom_range(0, 1)) : (mode_b == 1);
      end
   end

   // Beat collector and stream-protocol observers.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (aresetn) begin
            if (ax_a.tvalid && ax_a.tready) begin
               got_a.push_back({ax_a.tuser, 1'b0, ax_a.tdata});
               got_a_cyc.push_back(cyc);
            end
            if (ax_b.tvalid && ax_b.tready) got_b.push_back({ax_b.tuser, 2'b00, ax_b.tdata});
            if (hold_a && (!ax_a.tvalid || {ax_a.tuser, ax_a.tdata} != hold_val_a)) stab_viol++;
            if (hold_b && (!ax_b.tvalid || {ax_b.tuser, ax_b.tdata} != hold_val_b)) stab_viol++;
            hold_a = ax_a.tvalid && !ax_a.tready;
            hold_b = ax_b.tvalid && !ax_b.tready;
            hold_val_a = {ax_a.tuser, ax_a.tdata};
            hold_val_b = {ax_b.tuser, ax_b.tdata};
            if (!ax_a.tvalid && (ax_a.tdata != '0 || ax_a.tuser != '0)) zero_viol++;
            if (!ax_b.tvalid && (ax_b.tdata != '0 || ax_b.tuser != '0)) zero_viol++;
            if (ovr_a) ovr_cnt_a++;
         end else begin
            hold_a = 1'b0;
            hold_b = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic drive(input int d, input logic v);
      if (d == 0) rx_a = v;
      else        rx_b = v;
   endtask

   task automatic hold_bits(input int n);
      repeat (n * BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic realign();
      @(posedge clk); #1;
   endtask

   // Serialises one frame; the expected beat follows directly from the frame rules.
   task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                             input int par, input bit flip, input int nstop,
                             input logic [1:0] stops);
      logic       pbit, fe;
      logic [8:0] dm;
      pbit = 1'b0;
      fe   = 1'b0;
      dm   = '0;
      drive(d, 1'b0); hold_bits(1);
      for (int i = 0; i < nbits; i++) begin
         dm[i] = data[i];
         pbit ^= data[i];
         drive(d, data[i]); hold_bits(1);
      end
      if (par != 0) begin
         if (par == 1) pbit = ~pbit;
         drive(d, pbit ^ flip); hold_bits(1);
      end
      for (int i = 0; i < nstop; i++) begin
         if (i == nstop - 1) last_stop_cyc = cyc;
         if (!stops[i]) fe = 1'b1;
         drive(d, stops[i]); hold_bits(1);
      end
      drive(d, 1'b1);
      if (d == 0) exp_a.push_back({(par != 0) && flip, fe, dm});
      else        exp_b.push_back({(par != 0) && flip, fe, dm});
   endtask

   task automatic wait_beats(input int d, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if ((d == 0 ? got_a.size() : got_b.size()) >= n) break;
         @(negedge clk);
      end
      realign();
   endtask

   task automatic clear_all();
      got_a.delete(); got_b.delete(); got_a_cyc.delete();
      exp_a.delete(); exp_b.delete();
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (ax_a.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_a: got %b expected 0", ax_a.tvalid); end
      checks++; if (ax_a.tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata_a: got %h expected 00", ax_a.tdata); end
      checks++; if (ax_a.tuser !== 2'b00) begin errors++; $display("FAIL reset_tuser_a: got %b expected 00", ax_a.tuser); end
      checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun_a: got %b expected 0", ovr_a); end
      checks++; if (lvl_a !== 3'd0) begin errors++; $display("FAIL reset_level_a: got %0d expected 0", lvl_a); end
      checks++; if (ax_b.tvalid !== 1'b0 || lvl_b !== 3'd0) begin errors++; $display("FAIL reset_b: got valid %b level %0d expected 0/0", ax_b.tvalid, lvl_b); end
      aresetn = 1'b1;
      hold_bits(1);
   endtask

   task automatic test_basic();
      int dt;
      mode_a = 1; realign(); realign();
      clear_all();
      send_frame(0, 9'hA5, 8, 0, 1'b0, 1, 2'b11);
      wait_beats(0, 1, 2000);
      checks++;
      if (got_a.size() != 1) begin
         errors++; $display("FAIL basic_count: got %0d beats expected 1", got_a.size());
      end else begin
         checks++; if (got_a[0] !== 11'h0A5) begin errors++; $display("FAIL basic_a5: got %h expected 0a5", got_a[0]); end
         dt = got_a_cyc[0] - last_stop_cyc;
         checks++; if (dt < 30 || dt > 56) begin errors++; $display("FAIL basic_latency: got %0d cycles after stop-bit start expected 30..56", dt); end
      end
   endtask

   task automatic test_parity();
      mode_b = 1; realign(); realign();
      clear_all();
      send_frame(1, 9'h41, 7, 2, 1'b1, 2, 2'b11);
      send_frame(1, 9'h41, 7, 2, 1'b0, 2, 2'b11);
      send_frame(1, 9'h2A, 7, 2, 1'b0, 2, 2'b10);
      hold_bits(1);
      send_frame(1, 9'h13, 7, 2, 1'b1, 2, 2'b01);
      hold_bits(1);
      wait_beats(1, 4, 2000);
      checks++;
      if (got_b.size() != 4) begin
         errors++; $display("FAIL parity_count: got %0d beats expected 4", got_b.size());
      end else begin
         checks++; if (got_b[0] !== {2'b10, 9'h41}) begin errors++; $display("FAIL parity_err_41: got %h expected %h", got_b[0], {2'b10, 9'h41}); end
         checks++; if (got_b[1] !== {2'b00, 9'h41}) begin errors++; $display("FAIL parity_ok_41: got %h expected %h", got_b[1], {2'b00, 9'h41}); end
         checks++; if (got_b[2] !== {2'b01, 9'h2A}) begin errors++; $display("FAIL frame_first_stop: got %h expected %h", got_b[2], {2'b01, 9'h2A}); end
         checks++; if (got_b[3] !== {2'b11, 9'h13}) begin errors++; $display("FAIL both_errors: got %h expected %h", got_b[3], {2'b11, 9'h13}); end
      end
   endtask

   task automatic test_break();
      mode_a = 1; realign(); realign();
      clear_all();
      drive(0, 1'b0); hold_bits(20);
      drive(0, 1'b1); hold_bits(2);
      checks++;
      if (got_a.size() != 1) begin
         errors++; $display("FAIL break_count: got %0d beats expected 1", got_a.size());
      end else begin
         checks++; if (got_a[0] !== {2'b01, 9'h000}) begin errors++; $display("FAIL break_beat: got %h expected %h", got_a[0], {2'b01, 9'h000}); end
      end
      send_frame(0, 9'h96, 8, 0, 1'b0, 1, 2'b11);
      wait_beats(0, 2, 2000);
      checks++; if (got_a.size() != 2 || got_a[got_a.size()-1] !== {2'b00, 9'h096}) begin
         errors++; $display("FAIL after_break: got %0d beats, last %h expected 2 beats, last 096", got_a.size(), got_a[got_a.size()-1]);
      end
   endtask

   task automatic test_glitch();
      mode_a = 1; realign(); realign();
      clear_all();
      drive(0, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      drive(0, 1'b1); hold_bits(12);
      checks++; if (got_a.size() != 0) begin errors++; $display("FAIL glitch_beat: got %0d beats expected 0", got_a.size()); end
      send_frame(0, 9'h3C, 8, 0, 1'b0, 1, 2'b11);
      wait_beats(0, 1, 2000);
      checks++; if (got_a.size() != 1 || got_a[0] !== {2'b00, 9'h03C}) begin
         errors++; $display("FAIL after_glitch: got %0d beats, first %h expected 1 beat 03c", got_a.size(), got_a[0]);
      end
   endtask

   task automatic test_overrun();
      logic [10:0] e;
      mode_a = 0; realign(); realign();
      clear_all();
      ovr_cnt_a = 0;
      for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 8, 0, 1'b0, 1, 2'b11);
      checks++; if (lvl_a !== 3'd4) begin errors++; $display("FAIL ovr_level_full: got %0d expected 4", lvl_a); end
      checks++; if (ovr_cnt_a != 0) begin errors++; $display("FAIL ovr_early: got %0d pulses expected 0", ovr_cnt_a); end
      send_frame(0, 9'h05, 8, 0, 1'b0, 1, 2'b11);
      hold_bits(1);
      checks++; if (ovr_cnt_a != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulse cycles expected 1", ovr_cnt_a); end
      checks++; if (lvl_a !== 3'd4) begin errors++; $display("FAIL ovr_level_hold: got %0d expected 4", lvl_a); end
      mode_a = 1;
      wait_beats(0, 4, 200);
      repeat (10) realign();
      checks++;
      if (got_a.size() != 4) begin
         errors++; $display("FAIL drain_count: got %0d beats expected 4", got_a.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = {2'b00, 9'(i + 1)};
            checks++; if (got_a[i] !== e) begin errors++; $display("FAIL drain_order_%0d: got %h expected %h", i, got_a[i], e); end
         end
      end
      checks++; if (lvl_a !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", lvl_a); end
   endtask

   task automatic test_reset_mid();
      mode_a = 0; realign(); realign();
      clear_all();
      send_frame(0, 9'h11, 8, 0, 1'b0, 1, 2'b11);
      checks++; if (ax_a.tvalid !== 1'b1 || lvl_a !== 3'd1) begin errors++; $display("FAIL pre_reset: got valid %b level %0d expected 1/1", ax_a.tvalid, lvl_a); end
      drive(0, 1'b0); hold_bits(1);
      drive(0, 1'b1); hold_bits(1);
      drive(0, 1'b0); hold_bits(1);
      aresetn = 1'b0;
      repeat (3) realign();
      checks++; if (ax_a.tvalid !== 1'b0 || ax_a.tdata !== 8'h00 || ax_a.tuser !== 2'b00 || ovr_a !== 1'b0 || lvl_a !== 3'd0) begin
         errors++; $display("FAIL mid_reset_outputs: got valid %b data %h user %b ovr %b level %0d expected all 0",
                            ax_a.tvalid, ax_a.tdata, ax_a.tuser, ovr_a, lvl_a);
      end
      drive(0, 1'b1);
      repeat (4) realign();
      aresetn = 1'b1;
      hold_bits(1);
      clear_all();
      send_frame(0, 9'h5A, 8, 0, 1'b0, 1, 2'b11);
      for (int k = 0; k < 3; k++) begin
         realign();
         checks++; if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== 8'h5A) begin
            errors++; $display("FAIL stall_hold_%0d: got valid %b data %h expected 1/5a", k, ax_a.tvalid, ax_a.tdata);
         end
      end
      mode_a = 1;
      wait_beats(0, 1, 200);
      hold_bits(2);
      checks++; if (got_a.size() != 1 || got_a[0] !== {2'b00, 9'h05A}) begin
         errors++; $display("FAIL post_reset_beats: got %0d beats, first %h expected 1 beat 05a", got_a.size(), got_a[0]);
      end
   endtask

   task automatic test_random(input int d, input int n);
      logic [1:0] st;
      bit         flip;
      mode_a = (d == 0) ? 2 : 1;
      mode_b = (d == 1) ? 2 : 1;
      realign(); realign();
      clear_all();
      for (int i = 0; i < n; i++) begin
         st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         flip = 1'($urandom_range(0, 1));
         if (d == 0) send_frame(0, 9'($urandom), 8, 0, 1'b0, 1, {1'b1, st[0]});
         else        send_frame(1, 9'($urandom), 7, 2, flip, 2, st);
         if ((d == 0 && !st[0]) || (d == 1 && st != 2'b11)) hold_bits(1);
         else hold_bits(int'($urandom_range(0, 1)));
      end
      hold_bits(1);
      mode_a = 1; mode_b = 1;
      wait_beats(d, n, 500);
      if (d == 0) begin
         checks++; if (got_a.size() != exp_a.size()) begin errors++; $display("FAIL rand_a_count: got %0d expected %0d", got_a.size(), exp_a.size()); end
         for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL rand_a_%0d: got %h expected %h", i, got_a[i], exp_a[i]); end
         end
      end else begin
         checks++; if (got_b.size() != exp_b.size()) begin errors++; $display("FAIL rand_b_count: got %0d expected %0d", got_b.size(), exp_b.size()); end
         for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++; if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL rand_b_%0d: got %h expected %h", i, got_b[i], exp_b[i]); end
         end
      end
   endtask

   task automatic test_protocol();
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL stream_stability: got %0d violations expected 0", stab_viol); end
      checks++; if (zero_viol != 0) begin errors++; $display("FAIL idle_zero: got %0d nonzero idle samples expected 0", zero_viol); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
      test_overrun();
      test_reset_mid();
      test_random(0, 12);
      test_random(1, 10);
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
